// File: rtl/cic_gain_ctrl_if.sv
// Sample-stream and gain-control bundle between the CIC decimator and its AGC.
// master = sample source / gain consumer (CIC side), slave = cic_gain_ctrl.
interface cic_gain_ctrl_if #(
   parameter int INPUT_WIDTH = 12,
   parameter int GAIN_WIDTH  = 8
);

   logic signed [INPUT_WIDTH-1:0] sample_in;
   logic                          sample_clk;
   logic [GAIN_WIDTH-1:0]         gain;
   logic                          gain_update;
   logic                          locked;
   logic [INPUT_WIDTH-2:0]        peak;
   logic [1:0]                    state_o;

   modport master (
      output sample_in,
      output sample_clk,
      input  gain,
      input  gain_update,
      input  locked,
      input  peak,
      input  state_o
   );

   modport slave (
      input  sample_in,
      input  sample_clk,
      output gain,
      output gain_update,
      output locked,
      output peak,
      output state_o
   );

endinterface

// File: rtl/cic_gain_ctrl.sv
// Peak-tracking AGC for the CIC decimator: windowed peak measurement, +/-1 gain
// steps, measurement blanking while the comb flushes. Option: CIC_GAIN_CTRL_FAST_ATTACK_EN.
module cic_gain_ctrl #(
   parameter int INPUT_WIDTH = 12,
   parameter int GAIN_WIDTH  = 8,
   parameter int GAIN_INIT   = 20,
   parameter int GAIN_MIN    = 0,
   parameter int GAIN_MAX    = 52,
   parameter int WINDOW_LEN  = 256,
   parameter int SETTLE_LEN  = 8,
   parameter int HIGH_THRESH = 1536,
   parameter int LOW_THRESH  = 384
) (
   input  logic                 clk,
   input  logic                 arst,
   input  logic                 enable,
   cic_gain_ctrl_if.slave       bus
);

   localparam int MAG_W  = INPUT_WIDTH - 1;
   localparam int WCNT_W = $clog2(WINDOW_LEN + 1);
   localparam int SCNT_W = $clog2(SETTLE_LEN + 1);

   localparam logic [MAG_W-1:0]       FULL_SCALE = {MAG_W{1'b1}};
   localparam logic [INPUT_WIDTH-1:0] MOST_NEG   = {1'b1, {MAG_W{1'b0}}};
   localparam logic [MAG_W-1:0]       HI_TH      = MAG_W'(HIGH_THRESH);
   localparam logic [MAG_W-1:0]       LO_TH      = MAG_W'(LOW_THRESH);
   localparam logic [GAIN_WIDTH-1:0]  G_MIN      = GAIN_WIDTH'(GAIN_MIN);
   localparam logic [GAIN_WIDTH-1:0]  G_MAX      = GAIN_WIDTH'(GAIN_MAX);
   localparam logic [GAIN_WIDTH-1:0]  G_INIT     = GAIN_WIDTH'(GAIN_INIT);
   localparam logic [WCNT_W-1:0]      WIN_LAST   = WCNT_W'(WINDOW_LEN - 1);
   localparam logic [SCNT_W-1:0]      SET_LAST   = SCNT_W'(SETTLE_LEN - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      MEASURE = 2'd2,
      DECIDE  = 2'd3
   } state_t;

   state_t                  state;
   logic                    sample_clk_q;
   logic                    strobe;
   logic [INPUT_WIDTH-1:0]  sample_neg;
   logic [MAG_W-1:0]        mag;
   logic [MAG_W-1:0]        acc;
   logic [MAG_W-1:0]        acc_next;
   logic [WCNT_W-1:0]       wcnt;
   logic [SCNT_W-1:0]       scnt;
   logic [GAIN_WIDTH-1:0]   gain_q;
   logic                    gain_update_q;
   logic                    locked_q;
   logic [MAG_W-1:0]        peak_q;
   logic                    too_hot;
   logic                    too_cold;

   assign strobe = bus.sample_clk & ~sample_clk_q;

   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      sample_neg = ~bus.sample_in + 1'b1;
      if (bus.sample_in == MOST_NEG) begin
         mag = FULL_SCALE;
      end else if (bus.sample_in[INPUT_WIDTH-1]) begin
         mag = sample_neg[MAG_W-1:0];
      end else begin
         mag = bus.sample_in[MAG_W-1:0];
      end
      acc_next = (mag > acc) ? mag : acc;
      too_hot  = (peak_q >= HI_TH);
      too_cold = (peak_q < LO_TH);
   end

`ifdef CIC_GAIN_CTRL_FAST_ATTACK_EN
   logic clip_abort;
   assign clip_abort = (mag == FULL_SCALE) && (gain_q > G_MIN);
`endif

   // NOTE: state uses <= throughout so every branch sees the pre-edge register values.
   always_ff @(posedge clk) begin
      if (arst) begin
         state         <= IDLE;
         sample_clk_q  <= 1'b0;
         acc           <= '0;
         wcnt          <= '0;
         scnt          <= '0;
         gain_q        <= G_INIT;
         gain_update_q <= 1'b0;
         locked_q      <= 1'b0;
         peak_q        <= '0;
      end else begin
         sample_clk_q  <= bus.sample_clk;
         gain_update_q <= 1'b0;

         if (!enable && state != IDLE) begin
            // Dropping out holds gain and the last completed peak.
            state    <= IDLE;
            locked_q <= 1'b0;
            acc      <= '0;
            wcnt     <= '0;
            scnt     <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (enable) begin
                     state <= SETTLE;
                     scnt  <= '0;
                  end
               end

               SETTLE: begin
                  if (strobe) begin
                     if (scnt == SET_LAST) begin
                        state <= MEASURE;
                        wcnt  <= '0;
                        acc   <= '0;
                     end else begin
                        scnt <= scnt + 1'b1;
                     end
                  end
               end

               MEASURE: begin
                  if (strobe) begin
`ifdef CIC_GAIN_CTRL_FAST_ATTACK_EN
                     if (clip_abort) begin
                        gain_q        <= gain_q - 1'b1;
                        gain_update_q <= 1'b1;
                        locked_q      <= 1'b0;
                        peak_q        <= FULL_SCALE;
                        state         <= SETTLE;
                        scnt          <= '0;
                     end else
`endif
                     if (wcnt == WIN_LAST) begin
                        peak_q <= acc_next;
                        acc    <= acc_next;
                        state  <= DECIDE;
                     end else begin
                        acc  <= acc_next;
                        wcnt <= wcnt + 1'b1;
                     end
                  end
               end

               DECIDE: begin
                  // Any strobe landing here is deliberately ignored.
                  if (too_hot && gain_q > G_MIN) begin
                     gain_q        <= gain_q - 1'b1;
                     gain_update_q <= 1'b1;
                     locked_q      <= 1'b0;
                     state         <= SETTLE;
                     scnt          <= '0;
                  end else if (too_cold && gain_q < G_MAX) begin
                     gain_q        <= gain_q + 1'b1;
                     gain_update_q <= 1'b1;
                     locked_q      <= 1'b0;
                     state         <= SETTLE;
                     scnt          <= '0;
                  end else begin
                     locked_q <= ~too_hot & ~too_cold;
                     state    <= MEASURE;
                     wcnt     <= '0;
                     acc      <= '0;
                  end
               end
            endcase
         end
      end
   end

   assign bus.gain        = gain_q;
   assign bus.gain_update = gain_update_q;
   assign bus.locked      = locked_q;
   assign bus.peak        = peak_q;
   assign bus.state_o     = state;

endmodule

// File: tb/tb_cic_gain_ctrl.sv
// Self-checking bench for cic_gain_ctrl: three instances (GAIN_INIT 20/52/0) share one
// sample stream and are compared every clock against a window-level behavioural model.
module tb_cic_gain_ctrl;

   localparam int WINDOW_LEN = 4;
   localparam int SETTLE_LEN = 2;
   localparam int GMIN       = 0;
   localparam int GMAX       = 52;
   localparam int HIGH       = 1536;
   localparam int LOW        = 384;
   localparam int FULL       = 2047;

   localparam int P_IDLE    = 0;
   localparam int P_SETTLE  = 1;
   localparam int P_MEASURE = 2;
   localparam int P_DECIDE  = 3;

   logic              clk;
   logic              arst;
   logic              enable;
   logic signed [11:0] sample_in;
   logic              sample_clk;

   cic_gain_ctrl_if #(.INPUT_WIDTH(12), .GAIN_WIDTH(8)) bus0 ();
   cic_gain_ctrl_if #(.INPUT_WIDTH(12), .GAIN_WIDTH(8)) bus1 ();
   cic_gain_ctrl_if #(.INPUT_WIDTH(12), .GAIN_WIDTH(8)) bus2 ();

   assign bus0.sample_in  = sample_in;
   assign bus0.sample_clk = sample_clk;
   assign bus1.sample_in  = sample_in;
   assign bus1.sample_clk = sample_clk;
   assign bus2.sample_in  = sample_in;
   assign bus2.sample_clk = sample_clk;

   cic_gain_ctrl #(.GAIN_INIT(20), .WINDOW_LEN(WINDOW_LEN), .SETTLE_LEN(SETTLE_LEN))
      dut0 (.clk(clk), .arst(arst), .enable(enable), .bus(bus0));
   cic_gain_ctrl #(.GAIN_INIT(52), .WINDOW_LEN(WINDOW_LEN), .SETTLE_LEN(SETTLE_LEN))
      dut1 (.clk(clk), .arst(arst), .enable(enable), .bus(bus1));
   cic_gain_ctrl #(.GAIN_INIT(0), .WINDOW_LEN(WINDOW_LEN), .SETTLE_LEN(SETTLE_LEN))
      dut2 (.clk(clk), .arst(arst), .enable(enable), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    total  = 0;
   int    passes = 0;
   string ctx    = "init";

   // Model: per-instance phase, samples of the open window, and the visible outputs.
   int m_gain   [3];
   int m_mode   [3];
   int m_scnt   [3];
   int m_wn     [3];
   int m_peak   [3];
   int m_win    [3][WINDOW_LEN];
   bit m_locked [3];
   bit m_upd    [3];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic int magnitude(input int v);
      int a;
      a = (v < 0) ? -v : v;
      return (a > FULL) ? FULL : a;
   endfunction

   function automatic int junk();
      return int'($urandom_range(0, 4095)) - 2048;
   endfunction

   task automatic model_decide(input int k);
      bit hot, cold;
      hot  = (m_peak[k] >= HIGH);
      cold = (m_peak[k] < LOW);
      if (hot && m_gain[k] > GMIN) begin
         m_gain[k]--; m_upd[k] = 1; m_locked[k] = 0; m_mode[k] = P_SETTLE; m_scnt[k] = 0;
      end else if (cold && m_gain[k] < GMAX) begin
         m_gain[k]++; m_upd[k] = 1; m_locked[k] = 0; m_mode[k] = P_SETTLE; m_scnt[k] = 0;
      end else begin
         m_locked[k] = !hot && !cold;
         m_mode[k]   = P_MEASURE;
         m_wn[k]     = 0;
      end
   endtask

   task automatic model_sample(input int k, input int s);
      int  mg;
      bit  aborted;
      mg      = magnitude(s);
      aborted = 0;
`ifdef CIC_GAIN_CTRL_FAST_ATTACK_EN
      if (mg == FULL && m_gain[k] > GMIN) begin
         m_gain[k]--; m_upd[k] = 1; m_locked[k] = 0; m_peak[k] = FULL;
         m_mode[k] = P_SETTLE; m_scnt[k] = 0; aborted = 1;
      end
`endif
      if (!aborted) begin
         m_win[k][m_wn[k]] = mg;
         m_wn[k]++;
         if (m_wn[k] == WINDOW_LEN) begin
            m_peak[k] = 0;
            for (int i = 0; i < WINDOW_LEN; i++)
               if (m_win[k][i] > m_peak[k]) m_peak[k] = m_win[k][i];
            m_mode[k] = P_DECIDE;
         end
      end
   endtask

   task automatic model_edge(input bit stb, input int s);
      for (int k = 0; k < 3; k++) begin
         m_upd[k] = 0;
         if (!enable) begin
            if (m_mode[k] != P_IDLE) begin
               m_mode[k] = P_IDLE; m_locked[k] = 0; m_wn[k] = 0; m_scnt[k] = 0;
            end
         end else begin
            case (m_mode[k])
               P_IDLE:    begin m_mode[k] = P_SETTLE; m_scnt[k] = 0; end
               P_SETTLE:  if (stb) begin
                             m_scnt[k]++;
                             if (m_scnt[k] == SETTLE_LEN) begin m_mode[k] = P_MEASURE; m_wn[k] = 0; end
                          end
               P_MEASURE: if (stb) model_sample(k, s);
               default:   model_decide(k);
            endcase
         end
      end
   endtask

   task automatic check_dut(input int k, input logic [7:0] g, input logic u, input logic l,
                            input logic [10:0] p, input logic [1:0] st);
      check($sformatf("%s_gain%0d", ctx, k),   32'(g),  32'(m_gain[k]));
      check($sformatf("%s_upd%0d", ctx, k),    32'(u),  32'(m_upd[k]));
      check($sformatf("%s_locked%0d", ctx, k), 32'(l),  32'(m_locked[k]));
      check($sformatf("%s_peak%0d", ctx, k),   32'(p),  32'(m_peak[k]));
      check($sformatf("%s_state%0d", ctx, k),  32'(st), 32'(m_mode[k]));
   endtask

   task automatic check_all();
      check_dut(0, bus0.gain, bus0.gain_update, bus0.locked, bus0.peak, bus0.state_o);
      check_dut(1, bus1.gain, bus1.gain_update, bus1.locked, bus1.peak, bus1.state_o);
      check_dut(2, bus2.gain, bus2.gain_update, bus2.locked, bus2.peak, bus2.state_o);
   endtask

   // One clock: drive at the negedge, model the posedge, compare at the next negedge.
   task automatic tick(input bit stb, input int s);
      sample_clk = stb;
      sample_in  = 12'(s);
      @(negedge clk);
      model_edge(stb, s);
      check_all();
   endtask

   task automatic send(input int s, input int gap);
      tick(1'b1, s);
      repeat (gap) tick(1'b0, junk());
   endtask

   task automatic set_en(input bit v);
      enable = v;
      tick(1'b0, junk());
   endtask

   task automatic do_reset();
      arst   = 1'b1;
      enable = 1'b0;
      repeat (3) begin
         sample_clk = ~sample_clk;
         sample_in  = 12'(junk());
         @(negedge clk);
      end
      m_gain[0] = 20; m_gain[1] = 52; m_gain[2] = 0;
      for (int k = 0; k < 3; k++) begin
         m_mode[k] = P_IDLE; m_scnt[k] = 0; m_wn[k] = 0; m_peak[k] = 0;
         m_locked[k] = 0; m_upd[k] = 0;
      end
      check_all();
      sample_clk = 1'b0;
      arst       = 1'b0;
   endtask

   int cat;
   int v;

   initial begin
      arst       = 1'b1;
      enable     = 1'b0;
      sample_clk = 1'b0;
      sample_in  = '0;
      @(negedge clk);

      ctx = "reset";
      do_reset();

      ctx = "stepdown";
      set_en(1'b1);
      send(7, 1);
      send(-9, 1);
      send(100, 1);
      send(-1600, 1);
      send(200, 1);
      send(50, 1);
      check("stepdown_gain",  32'(bus0.gain), 32'd19);
      check("stepdown_peak",  32'(bus0.peak), 32'd1600);
      check("stepdown_upd",   32'(bus0.gain_update), 32'd1);
      check("stepdown_state", 32'(bus0.state_o), 32'd1);

      ctx = "stepup";
      repeat (18) send(200, 1);
      check("stepup_gain", 32'(bus0.gain), 32'd22);

      ctx = "lock";
      repeat (6) send(800, 1);
      check("lock_locked", 32'(bus0.locked), 32'd1);
      check("lock_state",  32'(bus0.state_o), 32'd2);
      check("lock_gain",   32'(bus0.gain), 32'd22);

      ctx = "limit_hi";
      repeat (12) send(10, 1);
      check("limit_hi_gain",   32'(bus1.gain), 32'd52);
      check("limit_hi_locked", 32'(bus1.locked), 32'd0);
      check("limit_hi_upd",    32'(bus1.gain_update), 32'd0);

      ctx = "clip";
      do_reset();
      set_en(1'b1);
      send(3, 1);
      send(-4, 1);
      send(5, 1);
      send(-2048, 1);
      send(5, 1);
      send(5, 1);
      check("clip_lo_gain", 32'(bus2.gain), 32'd0);
      check("clip_lo_peak", 32'(bus2.peak), 32'd2047);
      check("clip_gain",    32'(bus0.gain), 32'd19);

      ctx = "abort";
      repeat (4) send(200, 1);
      set_en(1'b0);
      check("abort_state", 32'(bus0.state_o), 32'd0);
      tick(1'b0, junk());
      set_en(1'b1);
      repeat (6) send(200, 2);

      ctx = "random";
      repeat (250) begin
         cat = int'($urandom_range(0, 3));
         case (cat)
            0:       v = int'($urandom_range(0, 766)) - 383;
            1:       v = int'($urandom_range(0, 3070)) - 1535;
            2:       v = junk();
            default: v = ($urandom_range(0, 1) == 0) ? -2048 : 2047;
         endcase
         send(v, int'($urandom_range(1, 3)));
         if ($urandom_range(0, 24) == 0) begin
            set_en(1'b0);
            repeat (int'($urandom_range(0, 2))) tick(1'b0, junk());
            set_en(1'b1);
         end
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/cic_gain_ctrl.md
Name: cic_gain_ctrl

Overview:
- Automatic gain controller for the CIC decimator. It watches the decimated output stream (data_out / data_clk), measures peak magnitude over fixed sample windows, and steps the CIC gain input so the output sits between two thresholds.
- After every gain change it blanks measurement until the comb pipeline has flushed.
- Sits between the CIC output and downstream demod logic, in the same clk domain as the CIC.

Parameters:
- INPUT_WIDTH, 12, width of the CIC output sample being monitored.
- GAIN_WIDTH, 8, width of the gain output (matches the CIC gain port).
- GAIN_INIT, 20, gain value after reset.
- GAIN_MIN, 0, lowest gain the controller may issue.
- GAIN_MAX, 52, highest gain the controller may issue (REGISTER_WIDTH - INPUT_WIDTH of the CIC).
- WINDOW_LEN, 256, decimated samples per measurement window (>=1).
- SETTLE_LEN, 8, decimated samples discarded after enable or any gain change (>=1).
- HIGH_THRESH, 1536, peak magnitude at or above which gain is decremented.
- LOW_THRESH, 384, peak magnitude below which gain is incremented (LOW_THRESH < HIGH_THRESH).

Ports:
- clk  in  1  system clock, same as CIC clk.
- arst  in  1  reset; synchronous to clk, active-high.
- enable  in  1  1 = run the AGC loop; 0 = hold gain.
- sample_in  in  INPUT_WIDTH  signed CIC data_out.
- sample_clk  in  1  CIC data_clk; a sample is taken on its rising edge.
- gain  out  GAIN_WIDTH  gain to the CIC.
- gain_update  out  1  one-cycle pulse in the cycle gain changes.
- locked  out  1  1 when the last window needed no gain change.
- peak  out  INPUT_WIDTH-1  peak magnitude of the last completed window.
- state_o  out  2  current FSM state (IDLE=0, SETTLE=1, MEASURE=2, DECIDE=3).

Behaviour:
- Sample strobe:
  - sample_clk is registered once.
  - strobe = sample_clk & ~sample_clk_q.
  - sample_in is captured in the strobe cycle; the CIC updates data_out on the same edge data_clk rises.
- Magnitude:
  - |sample_in| as an unsigned (INPUT_WIDTH-1)-bit value.
  - The most negative value saturates to 2^(INPUT_WIDTH-1)-1.
- Reset (arst=1 at a clk edge):
  - gain=GAIN_INIT, gain_update=0, locked=0, peak=0, state=IDLE.
  - Counters, peak accumulator and sample_clk_q are cleared.
  - Reset overrides every other input in that cycle.
- FSM:
  - IDLE: gain held. On enable=1 -> SETTLE, with the settle counter cleared.
  - SETTLE: counts strobes. On the SETTLE_LEN-th strobe -> MEASURE, with the window counter and accumulator cleared.
  - MEASURE:
    - Each strobe: acc = max(acc, magnitude), count+1.
    - On the WINDOW_LEN-th strobe (that sample included) -> DECIDE.
    - peak <= final acc on that same edge.
  - DECIDE (exactly 1 clk):
    - If peak >= HIGH_THRESH and gain > GAIN_MIN: gain-1, gain_update=1, locked=0 -> SETTLE.
    - Else if peak < LOW_THRESH and gain < GAIN_MAX: gain+1, gain_update=1, locked=0 -> SETTLE.
    - Otherwise no change, locked=1 -> MEASURE with a fresh window.
    - At a gain limit with the threshold still violated: no change, locked=0 -> MEASURE.
- enable=0 in any non-IDLE state:
  - -> IDLE on the next edge; gain keeps its current value.
  - locked=0; the accumulator and counters clear. peak keeps its last completed value.
- A strobe in the DECIDE cycle is dropped, not counted. Strobes are >=2 clk apart for DECIMATION_RATIO>=2.
- gain never leaves [GAIN_MIN, GAIN_MAX]. No wrap-around in counters: each is sized $clog2(max_len+1) and cleared on every state entry.
- Latency:
  - From the last window strobe to the gain change: 2 clk (MEASURE->DECIDE edge, then DECIDE edge).
  - gain_update is high during the cycle in which the new gain is first visible.

Optional Feature:
- Macro: CIC_GAIN_CTRL_FAST_ATTACK_EN.
- Defined:
  - In MEASURE, a strobe with magnitude == 2^(INPUT_WIDTH-1)-1 (full scale / clip) while gain > GAIN_MIN aborts the window.
  - On that same edge: gain-1, gain_update=1, locked=0, peak=full scale, -> SETTLE.
  - At gain == GAIN_MIN the clip is only accumulated, as normal.
- Undefined: clipped samples are treated like any other sample. The fast-attack logic is not present.

Test Plan:
- All test cases use WINDOW_LEN=4, SETTLE_LEN=2, GAIN_INIT=20.
- Reset/hold: arst for 3 clk with enable=0 and strobes present -> gain=20, locked=0, peak=0, state_o=0, no gain_update.
- Step down: enable=1, 2 settle strobes then samples {100,-1600,200,50} -> peak=1600; 2 clk after the 4th strobe gain=19 with a 1-clk gain_update; state_o=1.
- Step up and lock:
  - Constant sample 200 -> gain 20->21->22..., one step per 6 strobes.
  - Then switching to 800 -> the next window gives no change, locked=1, state_o returns to 2.
- Limits: GAIN_INIT=52 with samples of 10 -> gain stays 52, locked=0, no gain_update. GAIN_INIT=0 with sample -2048 -> peak=2047, gain stays 0.
- Mid-operation abort: deassert enable after 2 MEASURE strobes -> state_o=0 next clk, gain unchanged. Re-enable -> 2 settle strobes precede a full 4-sample window.
- Fast attack (macro defined): sample -2048 as the 2nd window strobe -> same-edge gain 20->19, gain_update=1, state_o=1. Without the macro, the same stimulus gives gain=19 only after window completion.
